count_display_decoder: RTL and testbench
========================================

Name: count_display_decoder

Overview:
- Consumer end of the 6-bit up/down counter's count bus. Samples count on a strobe and converts it serially (shift-add-3) to two BCD digits.
- Drives a time-multiplexed two-digit active-low 7-segment display.
- Flags wrap-around events and out-of-range counts.
- Sits between the counter and the board display pins.

Parameters:
- CNT_W, 6, width of the sampled count bus.
- MAX_COUNT, 20, highest legal count value; the counter wraps MAX_COUNT<->0.
- REFRESH_DIV, 1024, clk cycles each digit is driven before the scan advances (>=2).

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- count  in  CNT_W  counter value to display.
- load  in  1  one-cycle strobe: sample count this cycle.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse: new digits committed.
- bcd_tens  out  4  committed tens digit.
- bcd_ones  out  4  committed ones digit.
- wrap_up  out  1  one-cycle pulse with done: previous committed value MAX_COUNT, new value 0.
- wrap_down  out  1  one-cycle pulse with done: previous committed value 0, new value MAX_COUNT.
- range_err  out  1  sticky until next commit: last sampled count > MAX_COUNT.
- seg  out  7  {g,f,e,d,c,b,a}, active-low.
- digit_en  out  2  active-low digit enables; [0]=ones, [1]=tens.

Behaviour:
- Reset is synchronous and active-high, on clk. Every output and all state are defined by it regardless of the FSM state at assertion; an in-flight conversion is abandoned.
- Reset values:
  - busy=0, done=0, wrap_up=0, wrap_down=0, range_err=0.
  - bcd_tens=0, bcd_ones=0; previous-committed register=0.
  - Scan divider=0, scan digit=ones, digit_en=2'b10, seg shows "0".
  - FSM=IDLE, pending flag clear.
- FSM states IDLE, CONVERT, COMMIT.
  - IDLE: load=1 -> capture count into shift register, clear BCD scratch, bit counter=CNT_W-1, go to CONVERT. busy=1 from the next cycle.
  - CONVERT: one bit per cycle. Any BCD nibble >=5 gets +3, then the {bcd,bin} register shifts left by 1. Runs exactly CNT_W cycles, then goes to COMMIT.
  - COMMIT (1 cycle):
    - In range: write bcd_tens/bcd_ones, pulse done=1, evaluate wrap flags against the previous committed value, update the previous-committed register.
    - Out of range (captured value > MAX_COUNT): set range_err=1, keep bcd_tens/bcd_ones and the previous-committed value unchanged, still pulse done, no wrap pulses.
    - Next state: IDLE with busy=0, or straight back to CONVERT if pending is set.
- Latency: load in cycle N -> done, bcd_tens/bcd_ones, wrap_up/wrap_down and range_err valid in cycle N+CNT_W+1 (N+7 by default). Throughput is one conversion per CNT_W+2 cycles.
- load while busy: the value is stored in a one-deep pending register; a later load overwrites it (latest wins). It is consumed immediately after COMMIT with no IDLE cycle. load in the COMMIT cycle is also pended.
- range_err clears on the next in-range commit.
- wrap_up and wrap_down are never both 1. A commit equal to the previous value produces no pulse.
- Scan path, independent of the FSM:
  - Divider counts 0..REFRESH_DIV-1; on terminal count it toggles the scan digit.
  - digit_en and seg update in the same registered cycle, so there is no ghosting cycle.
  - Tens digit 0 is blanked (seg=7'h7F, digit still enabled).
  - While range_err=1, both digits show dash: only g lit, seg=7'h3F.
- Segment codes, active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19
  - 5=12, 6=02, 7=78, 8=00, 9=10

Decomposition:
- Shared package count_disp_pkg:
  - FSM state enum (IDLE, CONVERT, COMMIT).
  - Segment constants SEG_BLANK=7'h7F and SEG_DASH=7'h3F.
  - 10-entry BCD-to-segment constant table.
  - Default values of CNT_W and MAX_COUNT.
- One sub-module, seg7_scan: refresh divider, digit select, blanking and segment lookup. Inputs: tens, ones, range_err. Outputs: seg, digit_en.

Test Plan:
- Reset held 3 cycles mid-CONVERT -> next cycle busy=0, done=0, bcd_tens/bcd_ones=0/0, digit_en=2'b10, seg=7'h40.
- load with count=17 in cycle 10 -> cycle 17: done=1, bcd_tens=1, bcd_ones=7, no wrap pulse. Scan: tens shows 7'h79, ones shows 7'h78, each held REFRESH_DIV cycles.
- Commit 20, then load count=0 -> wrap_up=1 together with done, bcd=0/0, tens blanked (7'h7F). Then load count=20 -> wrap_down=1, bcd=2/0.
- load count=25 after committed 9 -> range_err=1, bcd stays 0/9, both digits seg=7'h3F. Next load count=3 -> range_err=0, bcd=0/3.
- load 5 in cycle 0, then loads 6 and 8 in cycles 2 and 4 -> commits 5 in cycle 7 and 8 in cycle 14; 6 never commits; busy stays high through cycle 14.
- Sweep count 0..20 up then 20..0 down, one load per 8 cycles -> every commit equals the reference BCD, exactly one wrap_up and zero spurious wrap pulses.

Source files
------------

// File: rtl/count_disp_pkg.sv
// Shared types and constants for the count display decoder: FSM states,
// active-low segment patterns and default bus parameters.
package count_disp_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      COMMIT  = 2'd2
   } state_t;

   localparam int CNT_W_DEF     = 6;
   localparam int MAX_COUNT_DEF = 20;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   // {g,f,e,d,c,b,a}, a zero bit lights the segment
   localparam logic [6:0] SEG_TABLE [10] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
      7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

   function automatic logic [6:0] seg_of(input logic [3:0] digit);
      if (digit > 4'd9) begin
         return SEG_BLANK;
      end
      return SEG_TABLE[digit];
   endfunction

endpackage

// File: rtl/count_display_decoder_seg7_scan.sv
// Two-digit time-multiplexed 7-segment driver: refresh divider, digit select,
// leading-zero blanking and dash display while the count is out of range.
module seg7_scan
   import count_disp_pkg::*;
#(
   parameter int REFRESH_DIV = 1024
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] tens,
   input  logic [3:0] ones,
   input  logic       range_err,
   output logic [6:0] seg,
   output logic [1:0] digit_en
);

   localparam int DIV_W = $clog2(REFRESH_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

   logic [DIV_W-1:0] div_cnt;
   logic             scan_tens;
   logic             scan_tens_next;
   logic [6:0]       seg_next;

   // Segments are chosen for the digit about to be selected, so the enable and
   // the pattern change on the same edge.
   always_comb begin
      scan_tens_next = (div_cnt == DIV_LAST) ? ~scan_tens : scan_tens;
      if (range_err) begin
         seg_next = SEG_DASH;
      end else if (scan_tens_next) begin
         seg_next = (tens == 4'd0) ? SEG_BLANK : seg_of(tens);
      end else begin
         seg_next = seg_of(ones);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt   <= '0;
         scan_tens <= 1'b0;
         digit_en  <= 2'b10;
         seg       <= SEG_TABLE[0];
      end else begin
         div_cnt   <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
         scan_tens <= scan_tens_next;
         digit_en  <= scan_tens_next ? 2'b01 : 2'b10;
         seg       <= seg_next;
      end
   end

endmodule

// File: rtl/count_display_decoder.sv
// Samples the counter bus on a strobe, converts it to two BCD digits with a
// serial shift-add-3, flags wraps and out-of-range values, and drives the display.
module count_display_decoder
   import count_disp_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int MAX_COUNT   = MAX_COUNT_DEF,
   parameter int REFRESH_DIV = 1024
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [CNT_W-1:0] count,
   input  logic             load,
   output logic             busy,
   output logic             done,
   output logic [3:0]       bcd_tens,
   output logic [3:0]       bcd_ones,
   output logic             wrap_up,
   output logic             wrap_down,
   output logic             range_err,
   output logic [6:0]       seg,
   output logic [1:0]       digit_en
);

   localparam int SCR_W = CNT_W + 8;
   localparam int BIT_W = $clog2(CNT_W + 1);
   localparam logic [CNT_W-1:0] MAX_VAL  = CNT_W'(MAX_COUNT);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CNT_W - 1);

   state_t           state, state_next;
   logic [SCR_W-1:0] scratch, adjusted, shifted;
   logic [CNT_W-1:0] cap_val, prev_val, pend_val, start_val;
   logic [BIT_W-1:0] bit_cnt;
   logic             pending, start;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (load) state_next = CONVERT;
         CONVERT: if (bit_cnt == '0) state_next = COMMIT;
         COMMIT:  state_next = (load || pending) ? CONVERT : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
   end

   // A load arriving in COMMIT is newer than anything pended, so it is taken
   // directly and the pending slot is simply dropped.
   always_comb begin
      start     = 1'b0;
      start_val = count;
      case (state)
         IDLE:    start = load;
         COMMIT: begin
            start     = load | pending;
            start_val = load ? count : pend_val;
         end
         default: start = 1'b0;
      endcase
   end

   always_comb begin
      adjusted = scratch;
      if (scratch[SCR_W-1 -: 4] >= 4'd5) begin
         adjusted[SCR_W-1 -: 4] = scratch[SCR_W-1 -: 4] + 4'd3;
      end
      if (scratch[CNT_W+3 -: 4] >= 4'd5) begin
         adjusted[CNT_W+3 -: 4] = scratch[CNT_W+3 -: 4] + 4'd3;
      end
      shifted = adjusted << 1;
   end

   // Results are registered on the final shift so they are visible during COMMIT.
   always_ff @(posedge clk) begin
      if (reset) begin
         scratch   <= '0;
         cap_val   <= '0;
         prev_val  <= '0;
         pend_val  <= '0;
         pending   <= 1'b0;
         bit_cnt   <= '0;
         bcd_tens  <= 4'd0;
         bcd_ones  <= 4'd0;
         done      <= 1'b0;
         wrap_up   <= 1'b0;
         wrap_down <= 1'b0;
         range_err <= 1'b0;
      end else begin
         done      <= 1'b0;
         wrap_up   <= 1'b0;
         wrap_down <= 1'b0;
         if (start) begin
            scratch <= {8'b0, start_val};
            cap_val <= start_val;
            bit_cnt <= LAST_BIT;
         end
         if (state == CONVERT) begin
            scratch <= shifted;
            bit_cnt <= bit_cnt - 1'b1;
            if (load) begin
               pending  <= 1'b1;
               pend_val <= count;
            end
            if (bit_cnt == '0) begin
               done <= 1'b1;
               if (cap_val > MAX_VAL) begin
                  range_err <= 1'b1;
               end else begin
                  range_err <= 1'b0;
                  bcd_tens  <= shifted[SCR_W-1 -: 4];
                  bcd_ones  <= shifted[CNT_W+3 -: 4];
                  prev_val  <= cap_val;
                  wrap_up   <= (prev_val == MAX_VAL) && (cap_val == '0);
                  wrap_down <= (prev_val == '0) && (cap_val == MAX_VAL);
               end
            end
         end
         if (state == COMMIT) begin
            pending <= 1'b0;
         end
      end
   end

   seg7_scan #(
      .REFRESH_DIV(REFRESH_DIV)
   ) u_scan (
      .clk      (clk),
      .reset    (reset),
      .tens     (bcd_tens),
      .ones     (bcd_ones),
      .range_err(range_err),
      .seg      (seg),
      .digit_en (digit_en)
   );

endmodule

// File: tb/tb_count_display_decoder.sv
// Scoreboard bench for count_display_decoder: stimulus pushes expected commits
// from a decimal reference model, a negedge monitor pops them on done.
module tb_count_display_decoder;

   localparam int CNT_W     = 6;
   localparam int MAX_COUNT = 20;
   localparam int RD        = 16;
   localparam int LAT       = CNT_W + 1;

   logic             clk;
   logic             reset;
   logic [CNT_W-1:0] count;
   logic             load;
   logic             busy, done, wrap_up, wrap_down, range_err;
   logic [3:0]       bcd_tens, bcd_ones;
   logic [6:0]       seg;
   logic [1:0]       digit_en;

   typedef struct {
      int t;
      int o;
      bit wu;
      bit wd;
      bit re;
      int at;
   } exp_t;

   exp_t exp_q[$];
   int   compared   = 0;
   int   mismatched = 0;
   int   cyc        = 0;
   int   prev_val   = 0;
   bit   in_sweep   = 0;
   int   sweep_wu   = 0;
   int   sweep_wd   = 0;

   count_display_decoder #(
      .CNT_W      (CNT_W),
      .MAX_COUNT  (MAX_COUNT),
      .REFRESH_DIV(RD)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .count    (count),
      .load     (load),
      .busy     (busy),
      .done     (done),
      .bcd_tens (bcd_tens),
      .bcd_ones (bcd_ones),
      .wrap_up  (wrap_up),
      .wrap_down(wrap_down),
      .range_err(range_err),
      .seg      (seg),
      .digit_en (digit_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Decimal reference: digits by division, wraps and range judged on values.
   function automatic void push_expected(input int v, input int at);
      exp_t e;
      e.at = at;
      if (v > MAX_COUNT) begin
         e.t = prev_val / 10; e.o = prev_val % 10;
         e.wu = 0; e.wd = 0; e.re = 1;
      end else begin
         e.t = v / 10; e.o = v % 10;
         e.wu = (prev_val == MAX_COUNT) && (v == 0);
         e.wd = (prev_val == 0) && (v == MAX_COUNT);
         e.re = 0;
         prev_val = v;
      end
      exp_q.push_back(e);
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         if (done) begin
            if (exp_q.size() == 0) begin
               check_output("unexpected_done", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check_output("commit_cycle", cyc, e.at);
               check_output("bcd_tens", bcd_tens, e.t);
               check_output("bcd_ones", bcd_ones, e.o);
               check_output("wrap_up", wrap_up, e.wu);
               check_output("wrap_down", wrap_down, e.wd);
               check_output("range_err", range_err, e.re);
            end
            if (in_sweep) begin
               sweep_wu += int'(wrap_up);
               sweep_wd += int'(wrap_down);
            end
         end else begin
            check_output("wrap_without_done", {wrap_up, wrap_down}, 0);
         end
      end
   end

   task automatic apply_stimulus(input int v);
      @(posedge clk);
      #1;
      load  = 1'b1;
      count = CNT_W'(v);
      push_expected(v, cyc + LAT);
      @(posedge clk);
      #1;
      load = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check_output("idle_timeout", busy, 0);
   endtask

   task automatic scan_observe(output logic [6:0] s_t, output logic [6:0] s_o, output int hold);
      logic [1:0] last;
      int n = 0;
      s_t  = 7'h7F;
      s_o  = 7'h7F;
      hold = 0;
      @(negedge clk);
      last = digit_en;
      while (digit_en == last && n < 4 * RD) begin
         @(negedge clk);
         n++;
      end
      if (digit_en == 2'b01) s_t = seg; else if (digit_en == 2'b10) s_o = seg;
      last = digit_en;
      while (digit_en == last && hold < 4 * RD) begin
         hold++;
         @(negedge clk);
      end
      if (digit_en == 2'b01) s_t = seg; else if (digit_en == 2'b10) s_o = seg;
   endtask

   initial begin
      logic [6:0] s_t, s_o;
      int hold, c0, low;
      reset = 1'b1;
      load  = 1'b0;
      count = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Conversion abandoned by a reset in the middle of CONVERT
      @(posedge clk); #1 load = 1'b1; count = 6'd12;
      @(posedge clk); #1 load = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_output("rst_busy", busy, 0);
      check_output("rst_done", done, 0);
      check_output("rst_tens", bcd_tens, 0);
      check_output("rst_ones", bcd_ones, 0);
      check_output("rst_range_err", range_err, 0);
      check_output("rst_digit_en", digit_en, 2'b10);
      check_output("rst_seg", seg, 7'h40);
      repeat (10) @(posedge clk);

      apply_stimulus(17);
      wait_idle();
      scan_observe(s_t, s_o, hold);
      check_output("seg_tens_17", s_t, 7'h79);
      check_output("seg_ones_17", s_o, 7'h78);
      check_output("scan_hold", hold, RD);

      apply_stimulus(20); wait_idle();
      apply_stimulus(0);  wait_idle();
      scan_observe(s_t, s_o, hold);
      check_output("seg_tens_blank", s_t, 7'h7F);
      check_output("seg_ones_0", s_o, 7'h40);
      apply_stimulus(20); wait_idle();

      apply_stimulus(9);  wait_idle();
      apply_stimulus(25); wait_idle();
      scan_observe(s_t, s_o, hold);
      check_output("seg_tens_dash", s_t, 7'h3F);
      check_output("seg_ones_dash", s_o, 7'h3F);
      apply_stimulus(3);  wait_idle();
      scan_observe(s_t, s_o, hold);
      check_output("seg_ones_3", s_o, 7'h30);

      // Loads while busy: 6 is overwritten by 8 before it is consumed
      @(posedge clk); #1 load = 1'b1; count = 6'd5;
      c0 = cyc;
      push_expected(5, c0 + 7);
      @(posedge clk); #1 load = 1'b0;
      @(posedge clk); #1 load = 1'b1; count = 6'd6;
      @(posedge clk); #1 load = 1'b0;
      @(posedge clk); #1 load = 1'b1; count = 6'd8;
      push_expected(8, c0 + 14);
      @(posedge clk); #1 load = 1'b0;
      low = 0;
      forever begin
         @(negedge clk);
         if (!busy) low++;
         if (cyc >= c0 + 14) break;
      end
      check_output("burst_busy_low_cycles", low, 0);
      @(negedge clk);
      check_output("burst_busy_after", busy, 0);

      apply_stimulus(20); wait_idle();
      in_sweep = 1;
      for (int v = 0; v <= MAX_COUNT; v++) begin
         apply_stimulus(v);
         repeat (6) @(posedge clk);
      end
      for (int v = MAX_COUNT; v >= 0; v--) begin
         apply_stimulus(v);
         repeat (6) @(posedge clk);
      end
      wait_idle();
      in_sweep = 0;
      check_output("sweep_wrap_up_count", sweep_wu, 1);
      check_output("sweep_wrap_down_count", sweep_wd, 0);

      for (int i = 0; i < 60; i++) begin
         apply_stimulus(int'($urandom_range(0, 40)));
         wait_idle();
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end

      repeat (4) @(posedge clk);
      @(negedge clk);
      check_output("scoreboard_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
